neurocam_result_serializer: RTL and testbench

// - Downstream stage of the NeuroCAM match core: captures each match result
//   (best address, Hamming distance, confidence) when match_valid pulses.
// - Drops results whose distance exceeds a runtime threshold and buffers the rest in a small FIFO.
// - Emits each buffered result as a 3-byte frame on an 8-bit valid/ready stream driving the TT output pins.

---
 rtl/neurocam_result_serializer.sv | 139 +++++++++++++
 tb/tb_neurocam_result_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/neurocam_result_serializer.sv
// rtl/neurocam_result_serializer.sv - threshold filter, result FIFO and 3-byte frame serializer
// Optional NEUROCAM_RESULT_STATS_EN adds saturating accepted/dropped counters.
module neurocam_result_serializer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DIST_W = 5,
  parameter int CONF_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DIST_W-1:0]        in_distance,
  input  logic [CONF_W-1:0]        in_confidence,
  input  logic [DIST_W-1:0]        thresh,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     drop_pulse
`ifdef NEUROCAM_RESULT_STATS_EN
  ,
  output logic [15:0]              stat_accepted,
  output logic [15:0]              stat_dropped
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DIST_W + CONF_W;

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  frame_q, frame_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              drop_q;

  logic accept, not_empty, full, pop, push, drop;

  assign accept    = in_valid && (in_distance <= thresh);
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  // A pop frees the slot on the same edge, so a push into a full FIFO still lands.
  assign pop       = not_empty && ((state_q == IDLE) || ((state_q == B2) && out_ready));
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_addr, in_distance, in_confidence};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drop_q      <= drop;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (not_empty) state_d = B0;
      B0:   if (out_ready) state_d = B1;
      B1:   if (out_ready) state_d = B2;
      B2:   if (out_ready) state_d = not_empty ? B0 : IDLE;
    endcase
  end

  // Output bytes are built from the next state so the registers present them one edge later.
  always_comb begin
    frame_d     = pop ? mem_q[rd_ptr_q] : frame_q;
    out_valid_d = (state_d != IDLE);
    out_last_d  = (state_d == B2);
    out_data_d  = 8'h00;
    unique case (state_d)
      IDLE: out_data_d = 8'h00;
      B0:   out_data_d = 8'h80 | 8'(frame_d[ENT_W-1 -: ADDR_W]);
      B1:   out_data_d = 8'(frame_d[CONF_W +: DIST_W]);
      B2:   out_data_d = frame_d[CONF_W-1:0];
    endcase
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign fifo_count = count_q;
  assign drop_pulse = drop_q;

`ifdef NEUROCAM_RESULT_STATS_EN
  logic [15:0] stat_acc_q, stat_drp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc_q <= '0;
      stat_drp_q <= '0;
    end else begin
      if (push && (stat_acc_q != 16'hFFFF)) stat_acc_q <= stat_acc_q + 16'd1;
      if (drop && (stat_drp_q != 16'hFFFF)) stat_drp_q <= stat_drp_q + 16'd1;
    end
  end

  assign stat_accepted = stat_acc_q;
  assign stat_dropped  = stat_drp_q;
`endif

endmodule

// File: tb/tb_neurocam_result_serializer.sv
// tb/tb_neurocam_result_serializer.sv - directed self-checking bench for neurocam_result_serializer
module tb_neurocam_result_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] in_addr;
  logic [4:0] in_distance;
  logic [7:0] in_confidence;
  logic [4:0] thresh;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [2:0] fifo_count;
  logic       drop_pulse;
`ifdef NEUROCAM_RESULT_STATS_EN
  logic [15:0] stat_accepted;
  logic [15:0] stat_dropped;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  neurocam_result_serializer #(.DEPTH(4), .ADDR_W(6), .DIST_W(5), .CONF_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_addr       (in_addr),
    .in_distance   (in_distance),
    .in_confidence (in_confidence),
    .thresh        (thresh),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .fifo_count    (fifo_count),
    .drop_pulse    (drop_pulse)
`ifdef NEUROCAM_RESULT_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_dropped  (stat_dropped)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable from posedge+1 to the next posedge; the handshake is judged at the negedge.
  task automatic step();
    @(negedge clk);
    if (exp_q.size() == 0)
      chk("idle_valid", 16'(out_valid), 16'd0);
    else if (out_valid && out_ready)
      chk("byte", 16'({out_last, out_data}), 16'(exp_q.pop_front()));
    else if (out_valid)
      chk("stall_hold", 16'({out_last, out_data}), 16'(exp_q[0]));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] a, input logic [4:0] d, input logic [7:0] c, input bit keep);
    in_addr       = a;
    in_distance   = d;
    in_confidence = c;
    in_valid      = 1'b1;
    if (keep) begin
      exp_q.push_back({1'b0, 8'h80 | {2'b00, a}});
      exp_q.push_back({1'b0, 3'b000, d});
      exp_q.push_back({1'b1, c});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    chk(tag, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_distance = '0;
    in_confidence = '0; thresh = 5'd5; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_last", 16'(out_last), 16'd0);
    chk("rst_data", 16'(out_data), 16'd0);
    chk("rst_count", 16'(fifo_count), 16'd0);
    chk("rst_drop", 16'(drop_pulse), 16'd0);
    rst_n = 1'b1;

    // Basic frame and latency
    send(6'h2A, 5'd3, 8'hC8, 1'b1);
    chk("lat_valid0", 16'(out_valid), 16'd0);
    chk("lat_count1", 16'(fifo_count), 16'd1);
    step();
    chk("b0_valid", 16'(out_valid), 16'd1);
    chk("b0_data", 16'(out_data), 16'hAA);
    chk("b0_last", 16'(out_last), 16'd0);
    chk("b0_count", 16'(fifo_count), 16'd0);
    step();
    chk("b1_data", 16'(out_data), 16'h03);
    chk("b1_last", 16'(out_last), 16'd0);
    step();
    chk("b2_data", 16'(out_data), 16'hC8);
    chk("b2_last", 16'(out_last), 16'd1);
    step();
    chk("end_valid", 16'(out_valid), 16'd0);

    // Above threshold: silently ignored
    thresh = 5'd2;
    send(6'h15, 5'd3, 8'h10, 1'b0);
    chk("thr_count", 16'(fifo_count), 16'd0);
    chk("thr_drop", 16'(drop_pulse), 16'd0);
    step();
    chk("thr_valid", 16'(out_valid), 16'd0);
    chk("thr_drop2", 16'(drop_pulse), 16'd0);
    thresh = 5'd5;

    // Fill while stalled, overflow drop, then gapless drain
    out_ready = 1'b0;
    send(6'h01, 5'd5, 8'h11, 1'b1);
    send(6'h3F, 5'd0, 8'h22, 1'b1);
    send(6'h15, 5'd1, 8'h33, 1'b1);
    send(6'h20, 5'd4, 8'h44, 1'b1);
    send(6'h0A, 5'd2, 8'h55, 1'b1);
    chk("full_count", 16'(fifo_count), 16'd4);
    chk("full_frame", 16'(out_data), 16'h81);
    chk("full_valid", 16'(out_valid), 16'd1);
    send(6'h11, 5'd3, 8'h66, 1'b0);
    chk("drop_hi", 16'(drop_pulse), 16'd1);
    chk("drop_count", 16'(fifo_count), 16'd4);
    step();
    chk("drop_lo", 16'(drop_pulse), 16'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("gapless_left", 16'(exp_q.size()), 16'd0);
    chk("gapless_idle", 16'(out_valid), 16'd0);
    chk("gapless_count", 16'(fifo_count), 16'd0);

    // Ready toggling mid-frame
    out_ready = 1'b0;
    send(6'h33, 5'd5, 8'h77, 1'b1);
    step();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    chk("toggle_left", 16'(exp_q.size()), 16'd0);
    out_ready = 1'b1;
    step();

    // Push coinciding with the B2->B0 pop while full
    out_ready = 1'b0;
    send(6'h05, 5'd1, 8'h81, 1'b1);
    send(6'h06, 5'd2, 8'h82, 1'b1);
    send(6'h07, 5'd3, 8'h83, 1'b1);
    send(6'h08, 5'd4, 8'h84, 1'b1);
    send(6'h09, 5'd5, 8'h85, 1'b1);
    chk("coin_full", 16'(fifo_count), 16'd4);
    out_ready = 1'b1;
    step();
    step();
    chk("coin_b2", 16'(out_last), 16'd1);
    send(6'h0B, 5'd0, 8'h86, 1'b1);
    chk("coin_count", 16'(fifo_count), 16'd4);
    chk("coin_nodrop", 16'(drop_pulse), 16'd0);
    drain("coin_drain", 40);
    step();
    chk("coin_idle", 16'(out_valid), 16'd0);
    chk("coin_empty", 16'(fifo_count), 16'd0);

    // Asynchronous reset during B1
    send(6'h1C, 5'd3, 8'h90, 1'b1);
    step();
    step();
    chk("pre_rst_b1", 16'(out_data), 16'h03);
`ifdef NEUROCAM_RESULT_STATS_EN
    chk("stat_acc", stat_accepted, 16'd14);
    chk("stat_drp", stat_dropped, 16'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(out_valid), 16'd0);
    chk("arst_last", 16'(out_last), 16'd0);
    chk("arst_count", 16'(fifo_count), 16'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    chk("post_count", 16'(fifo_count), 16'd0);
    chk("post_valid", 16'(out_valid), 16'd0);
`ifdef NEUROCAM_RESULT_STATS_EN
    chk("stat_acc_rst", stat_accepted, 16'd0);
    chk("stat_drp_rst", stat_dropped, 16'd0);
`endif
    send(6'h2D, 5'd4, 8'hA5, 1'b1);
    step();
    chk("post_valid1", 16'(out_valid), 16'd1);
    chk("post_b0", 16'(out_data), 16'hAD);
    drain("post_drain", 10);
`ifdef NEUROCAM_RESULT_STATS_EN
    chk("stat_acc_end", stat_accepted, 16'd1);
    chk("stat_drp_end", stat_dropped, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
